// File: rtl/ofm_write_addr_controller_pkg.sv
// Shared OFM addressing definitions: controller states, array geometry,
// address-width derivation and the tile clipping helper.
package ofm_write_addr_controller_pkg;

  localparam int OFM_SYSTOLIC_SIZE = 16;
  localparam int OFM_RAM_DEPTH     = 2378675;
  localparam int OFM_SIZE_W        = 9;
  localparam int OFM_CH_W          = 11;
  localparam int OFM_SQ_W          = 18;

  function automatic int ofm_addr_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int OFM_AW = ofm_addr_width(OFM_RAM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_WRITE   = 2'd2,
    ST_ADVANCE = 2'd3
  } ofm_state_e;

  // Clip a tile dimension to what is left of the layer.
  function automatic logic [OFM_CH_W-1:0] min_tile(input logic [OFM_CH_W-1:0] remaining,
                                                  input logic [OFM_CH_W-1:0] limit);
    return (remaining < limit) ? remaining : limit;
  endfunction

endpackage

// File: rtl/ofm_tile_walker.sv
// Tile position walker: tracks row / col_base / ch_base, the clipped tile
// extents and whether the current tile is the last of the layer.
module ofm_tile_walker
  import ofm_write_addr_controller_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = OFM_SYSTOLIC_SIZE,
  localparam int TW = $clog2(SYSTOLIC_SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  setup,
  input  logic                  advance,
  input  logic [OFM_SIZE_W-1:0] ofm_size,
  input  logic [OFM_CH_W-1:0]   ofm_channel,
  output logic [OFM_SIZE_W-1:0] row,
  output logic [OFM_SIZE_W-1:0] col_base,
  output logic [OFM_CH_W-1:0]   ch_base,
  output logic [TW-1:0]         tile_w,
  output logic [TW-1:0]         tile_ch,
  output logic                  last_tile
);

  logic [OFM_SIZE_W-1:0] row_q, row_d;
  logic [OFM_SIZE_W-1:0] col_base_q, col_base_d;
  logic [OFM_CH_W-1:0]   ch_base_q, ch_base_d;
  logic [TW-1:0]         tile_w_q, tile_w_d;
  logic [TW-1:0]         tile_ch_q, tile_ch_d;
  logic                  row_last, col_last, ch_last;

  assign row_last  = (row_q == ofm_size - OFM_SIZE_W'(1));
  assign col_last  = ({1'b0, col_base_q} + (OFM_SIZE_W + 1)'(tile_w_q)) == {1'b0, ofm_size};
  assign ch_last   = ({1'b0, ch_base_q} + (OFM_CH_W + 1)'(tile_ch_q)) == {1'b0, ofm_channel};
  assign last_tile = row_last && col_last && ch_last;

  always_comb begin
    row_d      = row_q;
    col_base_d = col_base_q;
    ch_base_d  = ch_base_q;
    tile_w_d   = tile_w_q;
    tile_ch_d  = tile_ch_q;
    if (init) begin
      row_d      = '0;
      col_base_d = '0;
      ch_base_d  = '0;
      tile_w_d   = '0;
      tile_ch_d  = '0;
    end else if (setup) begin
      tile_w_d  = TW'(min_tile({2'b00, ofm_size - col_base_q}, OFM_CH_W'(SYSTOLIC_SIZE)));
      tile_ch_d = TW'(min_tile(ofm_channel - ch_base_q, OFM_CH_W'(SYSTOLIC_SIZE)));
    end else if (advance) begin
      // Rows innermost, then column strips, then filter groups.
      if (row_last) begin
        row_d = '0;
        if (col_last) begin
          col_base_d = '0;
          ch_base_d  = ch_base_q + OFM_CH_W'(SYSTOLIC_SIZE);
        end else begin
          col_base_d = col_base_q + OFM_SIZE_W'(SYSTOLIC_SIZE);
        end
      end else begin
        row_d = row_q + OFM_SIZE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= '0;
      col_base_q <= '0;
      ch_base_q  <= '0;
      tile_w_q   <= '0;
      tile_ch_q  <= '0;
    end else begin
      row_q      <= row_d;
      col_base_q <= col_base_d;
      ch_base_q  <= ch_base_d;
      tile_w_q   <= tile_w_d;
      tile_ch_q  <= tile_ch_d;
    end
  end

  assign row      = row_q;
  assign col_base = col_base_q;
  assign ch_base  = ch_base_q;
  assign tile_w   = tile_w_q;
  assign tile_ch  = tile_ch_q;

endmodule

// File: rtl/ofm_write_addr_controller.sv
// OFM RAM write address generator: one pixel per handshake, written one cycle
// later at base + ch*size^2 + row*size + col, walking tiles in read order.
module ofm_write_addr_controller
  import ofm_write_addr_controller_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = OFM_SYSTOLIC_SIZE,
  parameter int OFM_RAM_SIZE  = OFM_RAM_DEPTH,
  parameter int DATA_WIDTH    = 16,
  localparam int AW = ofm_addr_width(OFM_RAM_SIZE),
  localparam int TW = $clog2(SYSTOLIC_SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         start_write_addr,
  input  logic [OFM_SIZE_W-1:0] ofm_size,
  input  logic [OFM_CH_W-1:0]   ofm_channel,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [AW-1:0]         ofm_addr,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  tile_done,
  output logic                  layer_done,
  output logic                  busy
);

  ofm_state_e            state_q, state_d;
  logic [AW-1:0]         base_q, base_d;
  logic [OFM_SIZE_W-1:0] size_q, size_d;
  logic [OFM_CH_W-1:0]   chn_q, chn_d;
  logic [OFM_SQ_W-1:0]   size_sq_q, size_sq_d;
  logic                  first_q, first_d;
  logic [TW-1:0]         col_cnt_q, col_cnt_d;
  logic [TW-1:0]         ch_cnt_q, ch_cnt_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [AW-1:0]         chan_addr_q, chan_addr_d;
  logic [AW-1:0]         ofm_addr_q, ofm_addr_d;
  logic                  write_en_q, write_en_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  tile_done_q, tile_done_d;
  logic                  layer_done_q, layer_done_d;

  logic                  walk_init, walk_setup, walk_advance;
  logic [OFM_SIZE_W-1:0] row, col_base;
  logic [OFM_CH_W-1:0]   ch_base;
  logic [TW-1:0]         tile_w, tile_ch;
  logic                  last_tile;
  logic                  hs, col_end, ch_end;
  logic [AW-1:0]         row_addr;

  ofm_tile_walker #(.SYSTOLIC_SIZE(SYSTOLIC_SIZE)) u_walker (
    .clk        (clk),
    .rst        (rst),
    .init       (walk_init),
    .setup      (walk_setup),
    .advance    (walk_advance),
    .ofm_size   (size_q),
    .ofm_channel(chn_q),
    .row        (row),
    .col_base   (col_base),
    .ch_base    (ch_base),
    .tile_w     (tile_w),
    .tile_ch    (tile_ch),
    .last_tile  (last_tile)
  );

  // Multiplies are only evaluated once per tile in SETUP; ch_base is zero on the
  // first tile, so the not-yet-loaded size_sq_q cannot matter there.
  assign row_addr = base_q + AW'(ch_base) * AW'(size_sq_q) + AW'(row) * AW'(size_q) + AW'(col_base);
  assign hs       = data_valid && (state_q == ST_WRITE);
  assign col_end  = (col_cnt_q == tile_w - TW'(1));
  assign ch_end   = (ch_cnt_q == tile_ch - TW'(1));

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    size_d       = size_q;
    chn_d        = chn_q;
    size_sq_d    = size_sq_q;
    first_d      = first_q;
    col_cnt_d    = col_cnt_q;
    ch_cnt_d     = ch_cnt_q;
    addr_d       = addr_q;
    chan_addr_d  = chan_addr_q;
    ofm_addr_d   = ofm_addr_q;
    write_data_d = write_data_q;
    write_en_d   = 1'b0;
    tile_done_d  = 1'b0;
    layer_done_d = 1'b0;
    walk_init    = 1'b0;
    walk_setup   = 1'b0;
    walk_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d    = start_write_addr;
          size_d    = ofm_size;
          chn_d     = ofm_channel;
          first_d   = 1'b1;
          walk_init = 1'b1;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        walk_setup = 1'b1;
        if (first_q) begin
          size_sq_d = OFM_SQ_W'(size_q) * OFM_SQ_W'(size_q);
        end
        first_d     = 1'b0;
        addr_d      = row_addr;
        chan_addr_d = row_addr;
        col_cnt_d   = '0;
        ch_cnt_d    = '0;
        state_d     = ST_WRITE;
      end
      ST_WRITE: begin
        if (hs) begin
          write_en_d   = 1'b1;
          ofm_addr_d   = addr_q;
          write_data_d = data_in;
          if (col_end) begin
            // Next channel plane: jump by size^2 from the segment start.
            col_cnt_d   = '0;
            chan_addr_d = chan_addr_q + AW'(size_sq_q);
            addr_d      = chan_addr_q + AW'(size_sq_q);
            if (ch_end) begin
              tile_done_d  = 1'b1;
              layer_done_d = last_tile;
              state_d      = ST_ADVANCE;
            end else begin
              ch_cnt_d = ch_cnt_q + TW'(1);
            end
          end else begin
            col_cnt_d = col_cnt_q + TW'(1);
            addr_d    = addr_q + AW'(1);
          end
        end
      end
      ST_ADVANCE: begin
        walk_advance = 1'b1;
        state_d      = last_tile ? ST_IDLE : ST_SETUP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      size_q       <= '0;
      chn_q        <= '0;
      size_sq_q    <= '0;
      first_q      <= 1'b0;
      col_cnt_q    <= '0;
      ch_cnt_q     <= '0;
      addr_q       <= '0;
      chan_addr_q  <= '0;
      ofm_addr_q   <= '0;
      write_en_q   <= 1'b0;
      write_data_q <= '0;
      tile_done_q  <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      size_q       <= size_d;
      chn_q        <= chn_d;
      size_sq_q    <= size_sq_d;
      first_q      <= first_d;
      col_cnt_q    <= col_cnt_d;
      ch_cnt_q     <= ch_cnt_d;
      addr_q       <= addr_d;
      chan_addr_q  <= chan_addr_d;
      ofm_addr_q   <= ofm_addr_d;
      write_en_q   <= write_en_d;
      write_data_q <= write_data_d;
      tile_done_q  <= tile_done_d;
      layer_done_q <= layer_done_d;
    end
  end

  assign data_ready = (state_q == ST_WRITE);
  assign busy       = (state_q != ST_IDLE);
  assign ofm_addr   = ofm_addr_q;
  assign write_en   = write_en_q;
  assign write_data = write_data_q;
  assign tile_done  = tile_done_q;
  assign layer_done = layer_done_q;

endmodule

// File: tb/tb_ofm_write_addr_controller.sv
// Randomized scoreboard bench for ofm_write_addr_controller against a
// loop-nest reference of the tile walk.
module tb_ofm_write_addr_controller;

  localparam int AW = 22;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, start, data_valid;
  logic [AW-1:0] start_write_addr;
  logic [8:0]    ofm_size;
  logic [10:0]   ofm_channel;
  logic [DW-1:0] data_in;
  logic          data_ready, write_en, tile_done, layer_done, busy;
  logic [AW-1:0] ofm_addr;
  logic [DW-1:0] write_data;

  ofm_write_addr_controller dut (
    .clk(clk), .rst(rst), .start(start), .start_write_addr(start_write_addr),
    .ofm_size(ofm_size), .ofm_channel(ofm_channel), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .ofm_addr(ofm_addr),
    .write_en(write_en), .write_data(write_data), .tile_done(tile_done),
    .layer_done(layer_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] addr; logic td; logic ld; } mdl_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic td; logic ld; int cyc; } exp_t;

  mdl_t model_q[$];
  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, errors = 0;
  int   tile_cnt = 0, write_cnt = 0, model_tiles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: the layer written out as plain nested loops over the tile order.
  task automatic build_model(input longint base, input int size, input int chn);
    model_q.delete();
    model_tiles = 0;
    for (int cb = 0; cb < chn; cb += 16)
      for (int c0 = 0; c0 < size; c0 += 16)
        for (int r = 0; r < size; r++) begin
          int tw = (size - c0 < 16) ? size - c0 : 16;
          int tc = (chn - cb < 16) ? chn - cb : 16;
          bit lastt = (r == size - 1) && (c0 + tw == size) && (cb + tc == chn);
          model_tiles++;
          for (int ch = cb; ch < cb + tc; ch++)
            for (int col = c0; col < c0 + tw; col++) begin
              mdl_t m;
              m.addr = AW'((base + longint'(ch) * size * size + longint'(r) * size + col)
                           % (longint'(1) << AW));
              m.td = (ch == cb + tc - 1) && (col == c0 + tw - 1);
              m.ld = m.td && lastt;
              model_q.push_back(m);
            end
        end
  endtask

  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      write_cnt++;
      if (tile_done === 1'b1) tile_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write: addr %0d written with no handshake outstanding", ofm_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("addr", 64'(ofm_addr), 64'(mon_e.addr));
        check("data", 64'(write_data), 64'(mon_e.data));
        check("tile_done", 64'(tile_done), 64'(mon_e.td));
        check("layer_done", 64'(layer_done), 64'(mon_e.ld));
        check("latency_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end else if (!rst && (tile_done !== 1'b0 || layer_done !== 1'b0)) begin
      checks++;
      errors++;
      $display("FAIL strobe_without_write: tile_done %0b layer_done %0b", tile_done, layer_done);
    end
  end

  task automatic run_layer(input logic [AW-1:0] base, input int size, input int chn,
                           input int gap, input int abort_at, input bit extra_start);
    int   sent = 0, budget = 0, total;
    bit   hs_pending = 0, did_extra = 0;
    exp_t e;
    build_model(longint'(base), size, chn);
    total = model_q.size();
    exp_q.delete();
    tile_cnt  = 0;
    write_cnt = 0;
    @(negedge clk);
    start            = 1'b1;
    start_write_addr = base;
    ofm_size         = 9'(size);
    ofm_channel      = 11'(chn);
    @(negedge clk);
    start_write_addr = AW'($urandom);
    ofm_size         = 9'($urandom_range(1, 416));
    ofm_channel      = 11'($urandom_range(1, 1024));
    while (1) begin
      start = 1'b0;
      if (hs_pending) begin
        data_valid = 1'b0;
        hs_pending = 0;
        if (abort_at != 0 && sent == abort_at) begin
          rst = 1'b1;
          @(negedge clk);
          check("rst_write_en", 64'(write_en), 64'd0);
          check("rst_busy", 64'(busy), 64'd0);
          check("rst_data_ready", 64'(data_ready), 64'd0);
          check("rst_queue_empty", 64'(exp_q.size()), 64'd0);
          rst = 1'b0;
          exp_q.delete();
          return;
        end
      end
      if (extra_start && !did_extra && sent == 7) begin
        start            = 1'b1;
        start_write_addr = AW'($urandom);
        ofm_size         = 9'd5;
        ofm_channel      = 11'd3;
        did_extra        = 1;
        check("busy_at_extra_start", 64'(busy), 64'd1);
      end
      if (!data_valid && sent < total && $urandom_range(0, 99) >= gap) begin
        data_valid = 1'b1;
        data_in    = DW'($urandom);
      end
      if (data_valid && data_ready) begin
        e.addr = model_q[sent].addr;
        e.data = data_in;
        e.td   = model_q[sent].td;
        e.ld   = model_q[sent].ld;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        sent++;
        hs_pending = 1;
      end
      if (sent == total && !hs_pending) break;
      budget++;
      if (budget > 20000) begin
        checks++;
        errors++;
        $display("FAIL timeout: %0d of %0d pixels accepted", sent, total);
        break;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 10 && (exp_q.size() != 0 || busy !== 1'b0); i++) @(negedge clk);
    check("drained", 64'(exp_q.size()), 64'd0);
    check("idle_after_layer", 64'(busy), 64'd0);
    check("write_count", 64'(write_cnt), 64'(total));
    check("tile_count", 64'(tile_cnt), 64'(model_tiles));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data_valid = 1'b0; data_in = '0;
    start_write_addr = '0; ofm_size = '0; ofm_channel = '0;
    repeat (3) @(negedge clk);
    check("reset_ofm_addr", 64'(ofm_addr), 64'd0);
    check("reset_write_en", 64'(write_en), 64'd0);
    check("reset_write_data", 64'(write_data), 64'd0);
    check("reset_data_ready", 64'(data_ready), 64'd0);
    check("reset_tile_done", 64'(tile_done), 64'd0);
    check("reset_layer_done", 64'(layer_done), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    run_layer(AW'(100), 3, 2, 0, 0, 0);
    run_layer(AW'(0), 20, 1, 0, 0, 0);
    run_layer(AW'(0), 2, 20, 0, 0, 0);
    run_layer(AW'(100), 3, 2, 50, 0, 0);
    run_layer(AW'(100), 3, 2, 0, 5, 0);
    run_layer(AW'(0), 3, 2, 0, 0, 0);
    run_layer(AW'(37), 5, 18, 30, 0, 1);
    run_layer(AW'((1 << AW) - 5), 3, 2, 20, 0, 0);
    run_layer(AW'(0), 1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      run_layer(AW'($urandom), $urandom_range(1, 12), $urandom_range(1, 24),
                $urandom_range(0, 60), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofm_write_addr_controller.md
# ofm_write_addr_controller

Write-side address generator for the OFM RAM. It accepts output pixels drained from the systolic array one per handshake and writes each one to its channel-major location in OFM RAM, using address = base + ch·ofm_size² + row·ofm_size + col. Tiles are walked in the same order the next layer's OFM read controller consumes them, so a finished layer can be read back directly as the next layer's IFM. It sits between the systolic-array drain/activation stage and the OFM RAM write port.

## Interface
- SYSTOLIC_SIZE, 16, max pixels per tile row and max filters per filter group
- OFM_RAM_SIZE, 2378675, OFM RAM depth; address width AW = $clog2(OFM_RAM_SIZE)
- DATA_WIDTH, 16, pixel width
- Reset is synchronous and active-high, on one clock.
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that latches the config and start_write_addr; ignored while busy=1
- start_write_addr  in  AW  layer base address
- ofm_size  in  9  output width/height, 1..416
- ofm_channel  in  11  number of output channels, 1..1024
- data_in  in  DATA_WIDTH  drained pixel
- data_valid  in  1  data_in is valid; must stay high until accepted
- data_ready  out  1  high only in state WRITE
- ofm_addr  out  AW  write address
- write_en  out  1  write strobe
- write_data  out  DATA_WIDTH  registered data_in
- tile_done  out  1  one-cycle pulse on the last write of a tile
- layer_done  out  1  one-cycle pulse on the last write of the layer
- busy  out  1  high from start until the cycle after layer_done

## Operation
- Tile: one output row `row`, columns col_base..col_base+tile_w−1, channels ch_base..ch_base+tile_ch−1.
  - tile_w = min(SYSTOLIC_SIZE, ofm_size−col_base)
  - tile_ch = min(SYSTOLIC_SIZE, ofm_channel−ch_base)
- Intra-tile order is channel-outer, column-inner.
  - ofm_addr increments by 1 along a row segment.
  - On a channel change, ofm_addr = row_addr + (ch+1)·ofm_size², where row_addr = base + ch_base·ofm_size² + row·ofm_size + col_base.
- Inter-tile order:
  - row++.
  - When row == ofm_size−1: row ← 0 and col_base += SYSTOLIC_SIZE.
  - When, in addition, col_base+tile_w == ofm_size: col_base ← 0 and ch_base += SYSTOLIC_SIZE.
  - When, in addition, ch_base+tile_ch == ofm_channel: the layer ends.
- FSM states: IDLE, SETUP, WRITE, ADVANCE.
  - IDLE→SETUP on start.
  - SETUP computes tile_w, tile_ch and row_addr, then →WRITE.
  - WRITE→ADVANCE on the handshake of the tile's last pixel.
  - ADVANCE→SETUP if more tiles remain, otherwise →IDLE.
- Arithmetic:
  - ofm_size² is precomputed in SETUP of the first tile into an 18-bit register.
  - All address sums are AW bits and truncate modulo 2^AW.
  - No multiply is allowed in the per-pixel path; only add/increment.
- data_valid outside WRITE is not consumed (data_ready=0). Upstream holds the pixel.

## Timing
- Reset values:
  - Outputs: ofm_addr=0, write_en=0, write_data=0, data_ready=0, tile_done=0, layer_done=0, busy=0.
  - Internal: state IDLE, all counters 0.
- Handshake occurs when data_valid && data_ready at a rising edge. The next cycle has write_en=1, with ofm_addr and write_data for that pixel (latency 1).
- WRITE sustains 1 pixel/cycle with no bubbles inside a tile.
- Per-tile overhead is 2 dead cycles (ADVANCE + SETUP), during which data_ready=0.
- tile_done and layer_done assert in the same cycle as the write_en of the last pixel.
- Stalls: data_valid low in WRITE leaves all counters unchanged and write_en=0.
- Reset asserted mid-layer abandons the layer immediately. write_en is 0 in the following cycle, and there are no partial-tile flushes.
- start coinciding with rst: rst wins.

## Structure
- Shared package (used with the OFM read controller) holds:
  - state encodings
  - SYSTOLIC_SIZE
  - AW derivation
  - the min-tile function
- Natural sub-module: ofm_tile_walker. It owns row, col_base and ch_base, tile_w/tile_ch, and the last-tile flags. The top module holds the per-pixel counters, the FSM and the output registers.

## Test plan
- ofm_size=3, ofm_channel=2, base=100, continuous valid:
  - Writes 100,101,102,109,110,111; then 103,104,105,112,113,114; then 106..108,115..117.
  - Three tile_done pulses; layer_done on the 18th write.
- ofm_size=20, ofm_channel=1, base=0:
  - Tile row0 writes 0..15. After 20 rows, col_base=16 and tile_w=4, so row0 writes 16..19.
  - 40 tiles total.
- ofm_channel=20, ofm_size=2:
  - Second filter group has tile_ch=4, and its first write address = 16·4 = 64.
- Random data_valid gaps (50%) with the first config: the address/data sequence is identical to the continuous case, and no write occurs on a non-handshake cycle.
- rst pulse during the 5th write, then restart with base=0:
  - write_en=0 one cycle after rst.
  - The new layer starts at address 0 with counters cleared.
- start pulsed while busy: no change to the address sequence.
